// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM states, requester count and
// the ALU opcode (op_mne) encodings used by the requesters.
package alu_arbiter_pkg;

  localparam int unsigned kNumReq = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_e;

  localparam logic [3:0] kADD = 4'd0;
  localparam logic [3:0] kSUB = 4'd1;
  localparam logic [3:0] kAND = 4'd2;
  localparam logic [3:0] kOR  = 4'd3;
  localparam logic [3:0] kXOR = 4'd4;
  localparam logic [3:0] kCMP = 4'd5;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant. A lone requester always wins;
// on contention the requester equal to the pointer wins.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic [kNumReq-1:0] req_valid_i,
  input  logic               ptr_i,
  input  logic               en_i,
  output logic [kNumReq-1:0] grant_o
);

  // One-hot (or zero) grant selection.
  always_comb begin
    grant_o = '0;
    if (en_i) begin
      if (req_valid_i == 2'b11) begin
        grant_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
        grant_o = req_valid_i;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the core datapath (requester 0) and
// the LFSR/parity engine (requester 1). Operands are latched at accept, the
// ALU result and flags are registered, and both sides use valid/ready.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 4,
  parameter int unsigned CFW = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [kNumReq-1:0] ReqValid,
  output logic [kNumReq-1:0] ReqReady,
  input  logic [DW-1:0]      ReqA0,
  input  logic [DW-1:0]      ReqB0,
  input  logic [OPW-1:0]     ReqOp0,
  input  logic [CFW-1:0]     ReqCf0,
  input  logic [DW-1:0]      ReqA1,
  input  logic [DW-1:0]      ReqB1,
  input  logic [OPW-1:0]     ReqOp1,
  input  logic [CFW-1:0]     ReqCf1,
  output logic [DW-1:0]      AluA,
  output logic [DW-1:0]      AluB,
  output logic [OPW-1:0]     AluOp,
  output logic [CFW-1:0]     AluCf,
  input  logic [DW-1:0]      AluOut,
  input  logic               AluZero,
  input  logic               AluNeg,
  output logic [kNumReq-1:0] RspValid,
  input  logic [kNumReq-1:0] RspReady,
  output logic [DW-1:0]      RspData,
  output logic               RspZero,
  output logic               RspNeg
);

  arb_state_e         state_q;
  logic               ptr_q;
  logic               owner_q;
  logic [DW-1:0]      a_q, b_q;
  logic [OPW-1:0]     op_q;
  logic [CFW-1:0]     cf_q;
  logic [DW-1:0]      rsp_data_q;
  logic               rsp_zero_q, rsp_neg_q;
  logic [kNumReq-1:0] rsp_valid_q;

  logic [kNumReq-1:0] grant;
  logic               arb_en;
  logic [DW-1:0]      a_d, b_d;
  logic [OPW-1:0]     op_d;
  logic [CFW-1:0]     cf_d;

  // Grants only in IDLE; Reset_n also gates it so ReqReady stays low while
  // reset is asserted even though IDLE's ready path is combinational.
  assign arb_en = (state_q == ARB_IDLE) && Reset_n;

  rr_arb2 u_rr_arb2 (
    .req_valid_i (ReqValid),
    .ptr_i       (ptr_q),
    .en_i        (arb_en),
    .grant_o     (grant)
  );

  // Operand source for the granted requester.
  always_comb begin
    a_d  = grant[1] ? ReqA1  : ReqA0;
    b_d  = grant[1] ? ReqB1  : ReqB0;
    op_d = grant[1] ? ReqOp1 : ReqOp0;
    cf_d = grant[1] ? ReqCf1 : ReqCf0;
  end

  assign ReqReady = grant;
  assign AluA     = a_q;
  assign AluB     = b_q;
  assign AluOp    = op_q;
  assign AluCf    = cf_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspZero  = rsp_zero_q;
  assign RspNeg   = rsp_neg_q;

  // Arbiter FSM with operand latches and registered response.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cf_q        <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|grant) begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cf_q    <= cf_d;
            owner_q <= grant[1];
            ptr_q   <= ~grant[1];
            state_q <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          rsp_data_q  <= AluOut;
          rsp_zero_q  <= AluZero;
          rsp_neg_q   <= AluNeg;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= ARB_RESP;
        end
        ARB_RESP: begin
          if (RspReady[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level
// model: expected winner from the round-robin rule, expected result from a
// behavioural ALU applied to the operands presented at accept time.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a [2];
  logic [7:0] req_b [2];
  logic [3:0] req_op [2];
  logic [2:0] req_cf [2];
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_op;
  logic [2:0] alu_cf;
  logic       alu_zero, alu_neg;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero, rsp_neg;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic        last_win;

  alu_arbiter #(.DW(8), .OPW(4), .CFW(3)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .ReqValid (req_valid),
    .ReqReady (req_ready),
    .ReqA0    (req_a[0]),
    .ReqB0    (req_b[0]),
    .ReqOp0   (req_op[0]),
    .ReqCf0   (req_cf[0]),
    .ReqA1    (req_a[1]),
    .ReqB1    (req_b[1]),
    .ReqOp1   (req_op[1]),
    .ReqCf1   (req_cf[1]),
    .AluA     (alu_a),
    .AluB     (alu_b),
    .AluOp    (alu_op),
    .AluCf    (alu_cf),
    .AluOut   (alu_out),
    .AluZero  (alu_zero),
    .AluNeg   (alu_neg),
    .RspValid (rsp_valid),
    .RspReady (rsp_ready),
    .RspData  (rsp_data),
    .RspZero  (rsp_zero),
    .RspNeg   (rsp_neg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural ALU: returns {zero, neg, result}.
  function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [7:0] r;
    case (op)
      kADD:       r = a + b;
      kSUB, kCMP: r = a - b;
      kAND:       r = a & b;
      kOR:        r = a | b;
      kXOR:       r = a ^ b;
      default:    r = a;
    endcase
    return {(r == 8'h00), r[7], r};
  endfunction

  always_comb {alu_zero, alu_neg, alu_out} = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [2:0] cf);
    req_a[i]  = a;
    req_b[i]  = b;
    req_op[i] = op;
    req_cf[i] = cf;
  endtask

  // One complete transaction: grant, issue, response with optional backpressure.
  task automatic run_op(input logic [1:0] vld, input int unsigned bp, input logic other_rdy);
    logic        w;
    logic [1:0]  oh;
    logic [9:0]  exp;
    logic [22:0] alu_in_exp;
    w  = (vld == 2'b11) ? ~last_win : vld[1];
    oh = w ? 2'b10 : 2'b01;
    req_valid = vld;
    rsp_ready = '0;
    #1;
    chk("grant", {30'd0, req_ready}, {30'd0, oh});
    exp        = alu_fn(req_a[w], req_b[w], req_op[w]);
    alu_in_exp = {req_a[w], req_b[w], req_op[w], req_cf[w]};
    @(posedge Clk); #1;
    last_win = w;
    req_valid[w] = 1'b0;
    req_a[w] = 8'($urandom);
    req_b[w] = 8'($urandom);
    #1;
    chk("issue_ready", {30'd0, req_ready}, 32'd0);
    chk("issue_rspvalid", {30'd0, rsp_valid}, 32'd0);
    chk("alu_inputs", {9'd0, alu_a, alu_b, alu_op, alu_cf}, {9'd0, alu_in_exp});
    @(posedge Clk); #1;
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp[7:0]});
    chk("rsp_flags", {30'd0, rsp_zero, rsp_neg}, {30'd0, exp[9:8]});
    for (int unsigned k = 0; k < bp; k++) begin
      rsp_ready[~w] = other_rdy;
      @(posedge Clk); #1;
      chk("bp_valid", {30'd0, rsp_valid}, {30'd0, oh});
      chk("bp_data", {22'd0, rsp_zero, rsp_neg, rsp_data}, {22'd0, exp});
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready[w]  = 1'b1;
    rsp_ready[~w] = other_rdy;
    @(posedge Clk); #1;
    rsp_ready = '0;
    chk("rsp_done", {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    Reset_n   = 1'b0;
    req_valid = 2'b11;
    rsp_ready = '0;
    for (int i = 0; i < 2; i++) set_req(i, 8'h00, 8'h00, kADD, 3'd0);
    last_win = 1'b1;

    // Reset state, with requests pending during reset.
    #3;
    chk("reset_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_rspvalid", {30'd0, rsp_valid}, 32'd0);
    chk("reset_rsp", {22'd0, rsp_zero, rsp_neg, rsp_data}, 32'd0);
    chk("reset_alu", {9'd0, alu_a, alu_b, alu_op, alu_cf}, 32'd0);
    req_valid = '0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Single request: 5 + 3.
    set_req(0, 8'h05, 8'h03, kADD, 3'd0);
    run_op(2'b01, 0, 1'b0);

    // Flags: 3 - 5 and compare-equal.
    set_req(1, 8'h03, 8'h05, kSUB, 3'b101);
    run_op(2'b10, 0, 1'b0);
    set_req(1, 8'h07, 8'h07, kCMP, 3'b010);
    run_op(2'b10, 0, 1'b0);

    // Backpressure with the non-owner's ready asserted.
    set_req(0, 8'h80, 8'h01, kOR, 3'b001);
    run_op(2'b01, 10, 1'b1);

    // Reset in the middle of ISSUE.
    set_req(0, 8'h11, 8'h22, kADD, 3'd0);
    req_valid = 2'b01;
    @(posedge Clk); #1;
    req_valid = 2'b11;
    Reset_n   = 1'b0;
    #1;
    chk("midreset_ready", {30'd0, req_ready}, 32'd0);
    chk("midreset_rspvalid", {30'd0, rsp_valid}, 32'd0);
    chk("midreset_data", {24'd0, rsp_data}, 32'd0);
    req_valid = '0;
    @(posedge Clk); #1;
    Reset_n  = 1'b1;
    last_win = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      chk("no_rsp_after_reset", {30'd0, rsp_valid}, 32'd0);
    end

    // Contention from reset: both valid, grants must alternate starting at 0.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)), 3'($urandom));
      run_op(2'b11, 0, 1'b0);
    end

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)), 3'($urandom));
      run_op(2'($urandom_range(1, 3)), $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
